// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-set input and encoded-word output handshakes of instr_encoder
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic [7:0]        err_cnt;
    logic              full;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err, err_cnt, full
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err, err_cnt, full
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs RISC-V R/I/S/B/U/J fields into a 32-bit word with a one-deep output register.
// Optional IMM_RANGE_CHECK_EN: reject immediates that do not fit their format (word becomes NOP, err set).
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input logic            clk,
    input logic            rst_n,
    input logic            clear,
    instr_encoder_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, HOLD, FULL} state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              err_q, err_d;
    logic              full_q, full_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       word;
    logic              bad_fmt;
    logic              bad_imm;
    logic              out_valid;
    logic              accept;

    assign out_valid    = state_q == HOLD;
    assign bus.in_ready = rst_n & ~full_q & (~out_valid | bus.out_ready);
    // clear wins over a simultaneous accept, so the word is simply not taken
    assign accept       = bus.in_valid & bus.in_ready & ~clear;

    assign bus.out_valid = out_valid;
    assign bus.out_instr = instr_q;
    assign bus.out_addr  = addr_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = cnt_q;
    assign bus.full      = full_q;

    // Pack the presented fields according to fmt; unused fields are dropped
    always_comb begin
        word    = '0;
        bad_fmt = 1'b0;
        case (bus.fmt)
            3'd0: word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            3'd1: word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            3'd2: word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
            3'd3: word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                          bus.imm[4:1], bus.imm[11], bus.opcode};
            3'd4: word = {bus.imm[31:12], bus.rd, bus.opcode};
            3'd5: word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.opcode};
            default: bad_fmt = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // A signed value fits when all bits above the field's sign bit copy it
    always_comb begin
        bad_imm = 1'b0;
        case (bus.fmt)
            3'd1, 3'd2: bad_imm = ~(&bus.imm[31:11] | ~|bus.imm[31:11]);
            3'd3:       bad_imm = ~(&bus.imm[31:12] | ~|bus.imm[31:12]) | bus.imm[0];
            3'd4:       bad_imm = |bus.imm[11:0];
            3'd5:       bad_imm = ~(&bus.imm[31:20] | ~|bus.imm[31:20]) | bus.imm[0];
            default:    bad_imm = 1'b0;
        endcase
    end
`else
    assign bad_imm = 1'b0;
`endif

    // Next state: flush, accept (possibly with drain), or drain only
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        full_d  = full_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = EMPTY;
            instr_d = '0;
            addr_d  = '0;
            ptr_d   = '0;
            err_d   = 1'b0;
            full_d  = 1'b0;
        end else if (accept) begin
            state_d = HOLD;
            instr_d = (bad_fmt | bad_imm) ? NOP : word;
            addr_d  = ptr_q;
            ptr_d   = ptr_q + ADDR_W'(1);
            err_d   = bad_fmt | bad_imm;
            full_d  = full_q | (&ptr_q);
            cnt_d   = ((bad_fmt | bad_imm) & ~&cnt_q) ? cnt_q + 8'd1 : cnt_q;
        end else if (out_valid & bus.out_ready) begin
            state_d = full_q ? FULL : EMPTY;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            instr_q <= '0;
            addr_q  <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            full_q  <= full_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
